// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle controller: opcodes, ALU ops,
// select codes, FSM states and the decoded control bundle.
package kgp_ctrl_pkg;

   localparam int CTRL_ALUOP_W = 4;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b000001;
   localparam logic [5:0] OPC_SW    = 6'b000010;
   localparam logic [5:0] OPC_ADDI  = 6'b000011;
   localparam logic [5:0] OPC_COMPI = 6'b000100;
   localparam logic [5:0] OPC_B     = 6'b000101;
   localparam logic [5:0] OPC_BL    = 6'b000110;
   localparam logic [5:0] OPC_BCY   = 6'b000111;
   localparam logic [5:0] OPC_BNCY  = 6'b001000;
   localparam logic [5:0] OPC_BR    = 6'b001001;
   localparam logic [5:0] OPC_BLTZ  = 6'b001010;
   localparam logic [5:0] OPC_BZ    = 6'b001011;
   localparam logic [5:0] OPC_BNZ   = 6'b001100;

   // R-type funct values map one-to-one onto these ALU codes
   localparam logic [CTRL_ALUOP_W-1:0] ALU_ADD   = 4'd0;
   localparam logic [CTRL_ALUOP_W-1:0] ALU_COMP  = 4'd1;
   localparam logic [CTRL_ALUOP_W-1:0] ALU_XOR   = 4'd2;
   localparam logic [CTRL_ALUOP_W-1:0] ALU_AND   = 4'd3;
   localparam logic [CTRL_ALUOP_W-1:0] ALU_SHLL  = 4'd4;
   localparam logic [CTRL_ALUOP_W-1:0] ALU_SHRL  = 4'd5;
   localparam logic [CTRL_ALUOP_W-1:0] ALU_SHLLV = 4'd6;
   localparam logic [CTRL_ALUOP_W-1:0] ALU_SHRLV = 4'd7;
   localparam logic [CTRL_ALUOP_W-1:0] ALU_SHRA  = 4'd8;
   localparam logic [CTRL_ALUOP_W-1:0] ALU_SHRAV = 4'd9;
   localparam logic [CTRL_ALUOP_W-1:0] FN_LAST   = 4'd9;

   localparam logic [1:0] EXT_SIGN  = 2'b00;
   localparam logic [1:0] EXT_ZERO  = 2'b01;
   localparam logic [1:0] EXT_SHAMT = 2'b10;

   localparam logic [1:0] DEST_RD   = 2'b00;
   localparam logic [1:0] DEST_RT   = 2'b01;
   localparam logic [1:0] DEST_LINK = 2'b10;

   localparam logic [1:0] FLAG_NONE  = 2'b00;
   localparam logic [1:0] FLAG_ZERO  = 2'b01;
   localparam logic [1:0] FLAG_SIGN  = 2'b10;
   localparam logic [1:0] FLAG_CARRY = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   typedef struct packed {
      logic [CTRL_ALUOP_W-1:0] alu_op;
      logic                    alu_src;
      logic [1:0]              ext_type;
      logic [1:0]              dest_sel;
      logic [1:0]              flag_sel;
      logic                    br_cond;
      logic                    br_neg;
      logic                    branch;
      logic                    go_to_reg;
      logic                    mem_access;
      logic                    mem_we;
      logic                    mem_to_reg;
      logic                    reg_write;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/kgp_decode_rom.sv
// Combinational KGP-RISC decode table: opcode/funct to control bundle plus an
// illegal-encoding flag (undefined encodings always yield an all-zero bundle).
module kgp_decode_rom
   import kgp_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int FUNCT_W = 10
) (
   input  logic [OP_W-1:0]    opcode_i,
   input  logic [FUNCT_W-1:0] funct_i,
   output ctrl_t              ctrl_o,
   output logic               illegal_o
);

   // Decode table
   always_comb begin
      ctrl_o    = CTRL_NOP;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_W'(OPC_RTYPE): begin
            if (funct_i <= FUNCT_W'(FN_LAST)) begin
               ctrl_o.alu_op    = funct_i[CTRL_ALUOP_W-1:0];
               ctrl_o.dest_sel  = DEST_RD;
               ctrl_o.reg_write = 1'b1;
               case (funct_i[CTRL_ALUOP_W-1:0])
                  ALU_SHLL, ALU_SHRL, ALU_SHRA: begin
                     ctrl_o.alu_src  = 1'b1;
                     ctrl_o.ext_type = EXT_SHAMT;
                  end
                  default: ctrl_o.alu_src = 1'b0;
               endcase
            end else begin
               illegal_o = 1'b1;
            end
         end
         OP_W'(OPC_LW): begin
            ctrl_o.alu_op     = ALU_ADD;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.ext_type   = EXT_SIGN;
            ctrl_o.dest_sel   = DEST_RT;
            ctrl_o.mem_access = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
         end
         OP_W'(OPC_SW): begin
            ctrl_o.alu_op     = ALU_ADD;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.ext_type   = EXT_SIGN;
            ctrl_o.mem_access = 1'b1;
            ctrl_o.mem_we     = 1'b1;
         end
         OP_W'(OPC_ADDI), OP_W'(OPC_COMPI): begin
            ctrl_o.alu_op    = (opcode_i == OP_W'(OPC_ADDI)) ? ALU_ADD : ALU_COMP;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.ext_type  = EXT_SIGN;
            ctrl_o.dest_sel  = DEST_RT;
            ctrl_o.reg_write = 1'b1;
         end
         OP_W'(OPC_B): ctrl_o.branch = 1'b1;
         OP_W'(OPC_BL): begin
            ctrl_o.branch   = 1'b1;
            ctrl_o.dest_sel = DEST_LINK;
         end
         OP_W'(OPC_BCY), OP_W'(OPC_BNCY): begin
            ctrl_o.branch   = 1'b1;
            ctrl_o.br_cond  = 1'b1;
            ctrl_o.br_neg   = (opcode_i == OP_W'(OPC_BNCY));
            ctrl_o.flag_sel = FLAG_CARRY;
         end
         OP_W'(OPC_BR): begin
            ctrl_o.go_to_reg = 1'b1;
            ctrl_o.dest_sel  = DEST_LINK;
            ctrl_o.reg_write = 1'b1;
         end
         OP_W'(OPC_BLTZ): begin
            ctrl_o.branch   = 1'b1;
            ctrl_o.br_cond  = 1'b1;
            ctrl_o.flag_sel = FLAG_SIGN;
         end
         OP_W'(OPC_BZ), OP_W'(OPC_BNZ): begin
            ctrl_o.branch   = 1'b1;
            ctrl_o.br_cond  = 1'b1;
            ctrl_o.br_neg   = (opcode_i == OP_W'(OPC_BNZ));
            ctrl_o.flag_sel = FLAG_ZERO;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/kgp_multicycle_ctrl.sv
// KGP-RISC multi-cycle sequencer: IDLE/DECODE/EXEC/MEM/WB/TRAP with memory-ack
// timeout and retire counter. Define KGP_ILLEGAL_TRAP_EN to trap undefined encodings.
module kgp_multicycle_ctrl
   import kgp_ctrl_pkg::*;
#(
   parameter int OP_W     = 6,
   parameter int FUNCT_W  = 10,
   parameter int ALUOP_W  = 4,
   parameter int MEM_TO_W = 8,
   parameter int CNT_W    = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               instr_valid_i,
   output logic               instr_ready_o,
   input  logic [OP_W-1:0]    opcode_i,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic               flush_i,
   input  logic               mem_ack_i,
   output logic [ALUOP_W-1:0] alu_op_o,
   output logic               alu_src_o,
   output logic [1:0]         ext_type_o,
   output logic [1:0]         dest_sel_o,
   output logic [1:0]         flag_sel_o,
   output logic               br_cond_o,
   output logic               br_neg_o,
   output logic               branch_o,
   output logic               go_to_reg_o,
   output logic               alu_en_o,
   output logic               mem_req_o,
   output logic               mem_we_o,
   output logic               mem_to_reg_o,
   output logic               reg_we_o,
   output logic               busy_o,
   output logic               mem_timeout_o,
   output logic               illegal_trap_o,
   output logic [CNT_W-1:0]   retired_cnt_o
);

   // Last MEM cycle is the one whose increment would make the counter all-ones
   localparam logic [MEM_TO_W-1:0] TO_LAST = {{(MEM_TO_W-1){1'b1}}, 1'b0};

   state_e               state_q, state_d;
   logic [OP_W-1:0]      opcode_q;
   logic [FUNCT_W-1:0]   funct_q;
   ctrl_t                ctrl_q;
   ctrl_t                rom_ctrl_s;
   logic                 illegal_s;
   logic [MEM_TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0]     retired_q;
   logic                 timeout_q;
   logic                 retire_s;
   logic                 timeout_s;
   logic                 accept_s;
   logic                 live_s;

   kgp_decode_rom #(
      .OP_W    (OP_W),
      .FUNCT_W (FUNCT_W)
   ) u_decode_rom (
      .opcode_i  (opcode_q),
      .funct_i   (funct_q),
      .ctrl_o    (rom_ctrl_s),
      .illegal_o (illegal_s)
   );

   assign accept_s = (state_q == ST_IDLE) && instr_valid_i && !flush_i;
   assign live_s   = !rst_i && !flush_i;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, retire and timeout decisions
   always_comb begin
      state_d   = state_q;
      to_cnt_d  = '0;
      retire_s  = 1'b0;
      timeout_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) state_d = ST_DECODE;
            else          state_d = ST_IDLE;
         end
         ST_DECODE: begin
`ifdef KGP_ILLEGAL_TRAP_EN
            if (illegal_s) state_d = ST_TRAP;
            else           state_d = ST_EXEC;
`else
            state_d = ST_EXEC;
`endif
         end
         ST_EXEC: begin
            if (ctrl_q.mem_access) begin
               state_d = ST_MEM;
            end else if (ctrl_q.reg_write) begin
               state_d = ST_WB;
            end else begin
               state_d  = ST_IDLE;
               retire_s = 1'b1;
            end
         end
         ST_MEM: begin
            to_cnt_d = to_cnt_q + MEM_TO_W'(1);
            if (mem_ack_i) begin
               if (ctrl_q.mem_we) begin
                  state_d  = ST_IDLE;
                  retire_s = 1'b1;
               end else begin
                  state_d = ST_WB;
               end
            end else if (to_cnt_q == TO_LAST) begin
               state_d   = ST_IDLE;
               timeout_s = 1'b1;
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_WB: begin
            state_d  = ST_IDLE;
            retire_s = 1'b1;
         end
         ST_TRAP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Flush overrides every in-flight outcome, including a same-cycle ack
      if (flush_i && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         to_cnt_d  = '0;
         retire_s  = 1'b0;
         timeout_s = 1'b0;
      end else begin
         state_d = state_d;
      end
   end

   // Instruction latch, control bundle, timeout and retire counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         opcode_q  <= '0;
         funct_q   <= '0;
         ctrl_q    <= CTRL_NOP;
         to_cnt_q  <= '0;
         retired_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_s;
         if (accept_s) begin
            opcode_q <= opcode_i;
            funct_q  <= funct_i;
         end
         if ((state_q == ST_DECODE) && !flush_i) begin
            ctrl_q <= rom_ctrl_s;
         end
         if (retire_s) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   assign instr_ready_o = (state_q == ST_IDLE) && !rst_i;
   assign busy_o        = (state_q != ST_IDLE);
   assign alu_en_o      = (state_q == ST_EXEC) && live_s;
   assign mem_req_o     = (state_q == ST_MEM)  && live_s;
   assign reg_we_o      = (state_q == ST_WB)   && live_s;
   assign mem_timeout_o = timeout_q;
   assign retired_cnt_o = retired_q;

   assign alu_op_o     = ALUOP_W'(ctrl_q.alu_op);
   assign alu_src_o    = ctrl_q.alu_src;
   assign ext_type_o   = ctrl_q.ext_type;
   assign dest_sel_o   = ctrl_q.dest_sel;
   assign flag_sel_o   = ctrl_q.flag_sel;
   assign br_cond_o    = ctrl_q.br_cond;
   assign br_neg_o     = ctrl_q.br_neg;
   assign branch_o     = ctrl_q.branch;
   assign go_to_reg_o  = ctrl_q.go_to_reg;
   assign mem_we_o     = ctrl_q.mem_we;
   assign mem_to_reg_o = ctrl_q.mem_to_reg;

`ifdef KGP_ILLEGAL_TRAP_EN
   assign illegal_trap_o = (state_q == ST_TRAP) && live_s;
`else
   logic unused_illegal_s;
   assign unused_illegal_s = illegal_s;
   assign illegal_trap_o   = 1'b0;
`endif

endmodule
